top_wrapper: RTL and testbench

TOP_WRAPPER -- requirements
Module: top_wrapper

---
 rtl/top_wrapper.sv | 257 +++++++++++++++++++++++++
 tb/tb_top_wrapper.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top_wrapper.sv
// top_wrapper: 3x3 box blur over a ring of four line buffers.
// Define BLUR_ROUND_DIV_EN to round the divide-by-9 to nearest.
module top_wrapper #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inPixel,
  input  logic                  inPixelValid,
  output logic                  inPixelReady,
  output logic [DATA_WIDTH-1:0] outPixel,
  output logic                  outPixelValid,
  input  logic                  outPixelReady,
  output logic                  interrupt
);

  localparam int AW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int CW  = $clog2(IMG_WIDTH + 1);
  localparam int CSW = DATA_WIDTH + 2;
  localparam int SW  = DATA_WIDTH + 4;

  localparam logic [AW-1:0] LASTW  = AW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] PADCOL = CW'(IMG_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] mem [4][IMG_WIDTH];

  logic [1:0]    wrBuf;
  logic [AW-1:0] wrCol;
  logic [1:0]    rdBuf;
  logic [1:0]    rdB1;
  logic [1:0]    rdB2;
  logic [3:0]    full;
  logic [CW-1:0] rdCol;
  logic [AW-1:0] rdAddr;

  state_t state;
  state_t stateNext;

  logic inAcc;
  logic wrDone;
  logic adv;
  logic outAcc;
  logic rowDone;
  logic rowsReady;
  logic readEn;
  logic padRead;

  logic                  aValid;
  logic                  aEmit;
  logic                  aFirst;
  logic                  aLast;
  logic [DATA_WIDTH-1:0] pT;
  logic [DATA_WIDTH-1:0] pM;
  logic [DATA_WIDTH-1:0] pB;

  logic [CSW-1:0] cur;
  logic [CSW-1:0] cs1;
  logic [CSW-1:0] cs2;
  logic           bValid;
  logic           bLast;
  logic [SW-1:0]  bSum;
  logic [SW-1:0]  quot;
  logic           outLast;

  // Handshake and control qualifiers
  always_comb begin
    inPixelReady = ~full[wrBuf];
    inAcc        = inPixelValid & inPixelReady;
    wrDone       = inAcc & (wrCol == LASTW);
    adv          = ~outPixelValid | outPixelReady;
    outAcc       = outPixelValid & outPixelReady;
    rowDone      = outAcc & outLast;
    rdB1         = rdBuf + 2'd1;
    rdB2         = rdBuf + 2'd2;
    rowsReady    = full[rdBuf] & full[rdB1] & full[rdB2];
    padRead      = (rdCol == PADCOL);
    rdAddr       = padRead ? '0 : rdCol[AW-1:0];
  end

  // Line buffer storage, written one pixel per accepted input
  always_ff @(posedge clk) begin
    if (inAcc) begin
      mem[wrBuf][wrCol] <= inPixel;
    end
  end

  // Write pointer walks columns, then moves to the next buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrBuf <= '0;
      wrCol <= '0;
    end else if (inAcc) begin
      if (wrDone) begin
        wrBuf <= wrBuf + 2'd1;
        wrCol <= '0;
      end else begin
        wrCol <= wrCol + AW'(1);
      end
    end
  end

  // Buffer occupancy: set on row completion, cleared on row release
  always_ff @(posedge clk) begin
    if (!rst) begin
      full <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wrDone && (wrBuf == 2'(i))) begin
          full[i] <= 1'b1;
        end else if (rowDone && (rdBuf == 2'(i))) begin
          full[i] <= 1'b0;
        end
      end
    end
  end

  // Oldest buffer advances once its output row is fully drained
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdBuf     <= '0;
      interrupt <= 1'b0;
    end else begin
      interrupt <= rowDone;
      if (rowDone) begin
        rdBuf <= rdB1;
      end
    end
  end

  // Reader FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Reader FSM next state
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (rowsReady) begin
          stateNext = READ;
        end
      end
      READ: begin
        if (readEn && padRead) begin
          stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (rowDone) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Reader FSM outputs: one column read per advancing cycle
  always_comb begin
    readEn = 1'b0;
    unique case (state)
      READ:    readEn = adv;
      default: readEn = 1'b0;
    endcase
  end

  // Read column counter, one extra step for the right zero pad
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdCol <= '0;
    end else if (readEn) begin
      rdCol <= padRead ? '0 : rdCol + CW'(1);
    end
  end

  // Column fetch from the three oldest buffers
  always_ff @(posedge clk) begin
    if (readEn) begin
      pT <= padRead ? '0 : mem[rdBuf][rdAddr];
      pM <= padRead ? '0 : mem[rdB1][rdAddr];
      pB <= padRead ? '0 : mem[rdB2][rdAddr];
    end
  end

  // Fetch stage tags travel with the column data
  always_ff @(posedge clk) begin
    if (!rst) begin
      aValid <= 1'b0;
      aEmit  <= 1'b0;
      aFirst <= 1'b0;
      aLast  <= 1'b0;
    end else if (adv) begin
      aValid <= readEn;
      aEmit  <= readEn & (rdCol != '0);
      aFirst <= (rdCol == '0);
      aLast  <= padRead;
    end
  end

  // Vertical column sum of the fetched pixels
  always_comb begin
    cur = CSW'(pT) + CSW'(pM) + CSW'(pB);
  end

  // Horizontal window: previous two column sums plus current
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs1    <= '0;
      cs2    <= '0;
      bSum   <= '0;
      bValid <= 1'b0;
      bLast  <= 1'b0;
    end else if (adv) begin
      bValid <= aValid & aEmit;
      bLast  <= aValid & aLast;
      if (aValid) begin
        cs1  <= cur;
        cs2  <= aFirst ? '0 : cs1;
        bSum <= SW'(cs2) + SW'(cs1) + SW'(cur);
      end
    end
  end

  // Divide the window sum by nine
  always_comb begin
`ifdef BLUR_ROUND_DIV_EN
    quot = (bSum + SW'(4)) / SW'(9);
`else
    quot = bSum / SW'(9);
`endif
  end

  // Output register, held while the sink stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      outPixel      <= '0;
      outPixelValid <= 1'b0;
      outLast       <= 1'b0;
    end else if (adv) begin
      outPixel      <= DATA_WIDTH'(quot);
      outPixelValid <= bValid;
      outLast       <= bLast;
    end
  end

endmodule

// File: tb/tb_top_wrapper.sv
// tb_top_wrapper: randomized self-checking bench for top_wrapper.
// Expected pixels come from a direct 3x3 box-sum image model.
module tb_top_wrapper;

  localparam int DW = 8;
  localparam int W  = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] inPixel = '0;
  logic          inPixelValid = 1'b0;
  logic          inPixelReady;
  logic [DW-1:0] outPixel;
  logic          outPixelValid;
  logic          outPixelReady = 1'b0;
  logic          interrupt;

  int nChecks = 0;
  int nFails  = 0;
  int irqCount = 0;
  int img [8][W];
  int got [4*W];
  int gotCnt = 0;
  bit abortRun = 1'b0;

  top_wrapper #(
    .DATA_WIDTH(DW),
    .IMG_WIDTH (W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inPixel      (inPixel),
    .inPixelValid (inPixelValid),
    .inPixelReady (inPixelReady),
    .outPixel     (outPixel),
    .outPixelValid(outPixelValid),
    .outPixelReady(outPixelReady),
    .interrupt    (interrupt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst === 1'b1 && interrupt === 1'b1) irqCount++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int refPix(int r, int c);
    int s = 0;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (c + dc >= 0 && c + dc < W) s += img[r+dr][c+dc];
      end
    end
`ifdef BLUR_ROUND_DIV_EN
    return (s + 4) / 9;
`else
    return s / 9;
`endif
  endfunction

  task automatic doReset();
    rst = 1'b0;
    inPixelValid = 1'b0;
    outPixelReady = 1'b0;
    inPixel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic fillRandom(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = int'($urandom_range(0, 255));
  endtask

  task automatic feedRows(input int nrows, input int mode, input int maxPix);
    int sent = 0;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < W; c++) begin
        bit acc;
        int tries;
        if (abortRun || sent >= maxPix) begin
          inPixelValid = 1'b0;
          return;
        end
        if (mode != 0 && $urandom_range(0, 3) == 0) begin
          inPixelValid = 1'b0;
          @(posedge clk);
          #1;
        end
        inPixelValid = 1'b1;
        inPixel = DW'(img[r][c]);
        acc = 1'b0;
        tries = 0;
        while (!acc && !abortRun) begin
          @(negedge clk);
          acc = (inPixelReady === 1'b1);
          @(posedge clk);
          #1;
          tries++;
          if (!acc && tries > 20000) begin
            nChecks++;
            nFails++;
            $display("FAIL feed_timeout: got stuck at row %0d col %0d want accept", r, c);
            abortRun = 1'b1;
          end
        end
        sent++;
      end
    end
    inPixelValid = 1'b0;
  endtask

  task automatic collect(input int nOut, input int mode);
    int k = 0;
    int cyc = 0;
    int stallLeft = 0;
    bit stallDone = 1'b0;
    bit held = 1'b0;
    logic [DW-1:0] heldPix = '0;
    int lim = 20 * W + 8 * nOut;
    while (k < nOut && !abortRun) begin
      if (mode == 2 && !stallDone && (k % W) == 200) begin
        stallLeft = 10;
        stallDone = 1'b1;
      end
      if (stallLeft > 0) begin
        outPixelReady = 1'b0;
        stallLeft--;
      end else if (mode == 1) begin
        outPixelReady = ($urandom_range(0, 3) != 0);
      end else begin
        outPixelReady = 1'b1;
      end
      @(negedge clk);
      if (held) begin
        nChecks++;
        if (outPixelValid !== 1'b1 || outPixel !== heldPix) begin
          nFails++;
          $display("FAIL hold[%0d]: got v=%b p=%0d want v=1 p=%0d",
                   k, outPixelValid, outPixel, heldPix);
        end
      end
      held = (outPixelValid === 1'b1) && (outPixelReady === 1'b0);
      heldPix = outPixel;
      if (outPixelValid === 1'b1 && outPixelReady === 1'b1) begin
        int exp;
        exp = refPix(k / W, k % W);
        got[k] = int'(outPixel);
        nChecks++;
        if (outPixel !== DW'(exp)) begin
          nFails++;
          $display("FAIL pix[r%0d c%0d]: got %0d want %0d",
                   k / W, k % W, outPixel, exp);
        end
        k++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (k < nOut && cyc > lim) begin
        nChecks++;
        nFails++;
        $display("FAIL out_timeout: got %0d outputs want %0d", k, nOut);
        abortRun = 1'b1;
      end
    end
    outPixelReady = 1'b0;
    gotCnt = k;
  endtask

  task automatic runImage(input int nrows, input int fmode, input int cmode);
    int irq0;
    abortRun = 1'b0;
    irq0 = irqCount;
    fork
      feedRows(nrows, fmode, nrows * W);
      collect((nrows - 2) * W, cmode);
    join
    repeat (4) @(posedge clk);
    #1;
    nChecks++;
    if (gotCnt != (nrows - 2) * W) begin
      nFails++;
      $display("FAIL out_count: got %0d want %0d", gotCnt, (nrows - 2) * W);
    end
    nChecks++;
    if (irqCount - irq0 != nrows - 2) begin
      nFails++;
      $display("FAIL irq_count: got %0d want %0d", irqCount - irq0, nrows - 2);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    inPixelValid = 1'b0;
    outPixelReady = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (outPixelValid !== 1'b0) begin
      nFails++;
      $display("FAIL rst_valid: got %b want 0", outPixelValid);
    end
    nChecks++;
    if (interrupt !== 1'b0) begin
      nFails++;
      $display("FAIL rst_irq: got %b want 0", interrupt);
    end
    nChecks++;
    if (inPixelReady !== 1'b1) begin
      nFails++;
      $display("FAIL rst_ready: got %b want 1", inPixelReady);
    end
    nChecks++;
    if (outPixel !== '0) begin
      nFails++;
      $display("FAIL rst_pix: got %0d want 0", outPixel);
    end
    rst = 1'b1;
  endtask

  task automatic test_const90();
    doReset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) img[r][c] = 90;
    runImage(3, 0, 0);
    nChecks++;
    if (got[0] != 60 || got[W-1] != 60) begin
      nFails++;
      $display("FAIL c90_edge: got %0d/%0d want 60", got[0], got[W-1]);
    end
    nChecks++;
    if (got[1] != 90 || got[255] != 90 || got[W-2] != 90) begin
      nFails++;
      $display("FAIL c90_mid: got %0d/%0d/%0d want 90", got[1], got[255], got[W-2]);
    end
  endtask

  task automatic test_rows_9_18_27();
    doReset();
    for (int c = 0; c < W; c++) begin
      img[0][c] = 9;
      img[1][c] = 18;
      img[2][c] = 27;
    end
    runImage(3, 1, 1);
    nChecks++;
    if (got[0] != 12 || got[W-1] != 12) begin
      nFails++;
      $display("FAIL r9_edge: got %0d/%0d want 12", got[0], got[W-1]);
    end
    nChecks++;
    if (got[1] != 18 || got[300] != 18) begin
      nFails++;
      $display("FAIL r9_mid: got %0d/%0d want 18", got[1], got[300]);
    end
  endtask

  task automatic test_four_rows();
    int irq0;
    doReset();
    fillRandom(4);
    abortRun = 1'b0;
    feedRows(4, 0, 4 * W);
    @(negedge clk);
    nChecks++;
    if (inPixelReady !== 1'b0) begin
      nFails++;
      $display("FAIL full_ready: got %b want 0", inPixelReady);
    end
    @(posedge clk);
    #1;
    irq0 = irqCount;
    collect(W, 0);
    repeat (3) @(posedge clk);
    #1;
    nChecks++;
    if (irqCount - irq0 != 1) begin
      nFails++;
      $display("FAIL full_irq: got %0d want 1", irqCount - irq0);
    end
    nChecks++;
    if (inPixelReady !== 1'b1) begin
      nFails++;
      $display("FAIL free_ready: got %b want 1", inPixelReady);
    end
  endtask

  task automatic test_stall();
    doReset();
    fillRandom(4);
    runImage(4, 1, 2);
  endtask

  task automatic test_single_pixel();
    int want;
    doReset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < W; c++) img[r][c] = 0;
    img[1][100] = 8;
    runImage(3, 0, 0);
`ifdef BLUR_ROUND_DIV_EN
    want = 1;
`else
    want = 0;
`endif
    nChecks++;
    if (got[101] != want || got[99] != want) begin
      nFails++;
      $display("FAIL single_px: got %0d/%0d want %0d", got[99], got[101], want);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    fillRandom(6);
    runImage(6, 1, 1);
  endtask

  task automatic test_midrun_reset();
    doReset();
    fillRandom(3);
    abortRun = 1'b0;
    feedRows(1, 1, 300);
    doReset();
    fillRandom(3);
    runImage(3, 0, 1);
  endtask

  initial begin
    test_reset();
    test_const90();
    test_rows_9_18_27();
    test_four_rows();
    test_stall();
    test_single_pixel();
    test_back_to_back();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
